// File: rtl/multicycle_ctrl_v2_if.sv
// rtl/multicycle_ctrl_v2_if.sv - instruction/memory-status inputs and datapath control outputs of the multi-cycle controller
interface multicycle_ctrl_v2_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         OpCode;
  logic [5:0]         Funct;
  logic               MemReady;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               BranchNe;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               ExtOp;
  logic               LuiOp;
  logic [1:0]         MemtoReg;
  logic [1:0]         RegDst;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         PCSource;
  logic               Exception;
  logic [3:0]         State;

  modport slave (
    input  OpCode, Funct, MemReady,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA, ALUSrcB,
           ALUOp, PCSource, Exception, State
  );

  modport master (
    output OpCode, Funct, MemReady,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, ExtOp, LuiOp, MemtoReg, RegDst, ALUSrcA, ALUSrcB,
           ALUOp, PCSource, Exception, State
  );
endinterface

// File: rtl/multicycle_ctrl_v2.sv
// rtl/multicycle_ctrl_v2.sv - multi-cycle CPU control FSM with memory wait states; ILLEGAL_TRAP_EN adds an illegal-opcode trap state
module multicycle_ctrl_v2 #(
  parameter int ALUOP_W       = 4,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_v2_if.slave bus
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MADR = 4'd2, S_MRD = 4'd3, S_MWB = 4'd4,
    S_MWR = 4'd5, S_EXE = 4'd6, S_AWB = 4'd7, S_BR = 4'd8, S_JMP = 4'd9,
    S_LINK = 4'd10, S_TRAP = 4'd11
  } state_t;

  state_t r_state, w_next;

  logic w_rtype, w_jr, w_jalr, w_mem_ok;
  logic w_pcwrite, w_pcwcond, w_bne, w_iord, w_memread, w_memwrite, w_irwrite;
  logic w_regwrite, w_extop, w_luiop, w_exc;
  logic [1:0] w_memtoreg, w_regdst, w_srca, w_srcb, w_pcsrc;
  logic [3:0] w_aluop;

  assign w_rtype  = (bus.OpCode == 6'h00);
  assign w_jr     = w_rtype && (bus.Funct == 6'h08);
  assign w_jalr   = w_rtype && (bus.Funct == 6'h09);
  assign w_mem_ok = bus.MemReady || !MEM_HANDSHAKE;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IF;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = S_IF;
    w_pcwrite  = 1'b0;
    w_pcwcond  = 1'b0;
    w_bne      = 1'b0;
    w_iord     = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_extop    = 1'b0;
    w_luiop    = 1'b0;
    w_exc      = 1'b0;
    w_memtoreg = 2'b00;
    w_regdst   = 2'b00;
    w_srca     = 2'b00;
    w_srcb     = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluop    = 4'b0000;
    case (r_state)
      S_IF: begin
        w_memread = 1'b1;
        w_srcb    = 2'b01;
        w_aluop   = {bus.OpCode[0], 3'b000};
        w_irwrite = w_mem_ok;
        w_pcwrite = w_mem_ok;
        w_next    = w_mem_ok ? S_ID : S_IF;
      end
      S_ID: begin
        w_srcb  = 2'b11;
        w_aluop = {bus.OpCode[0], 3'b000};
        case (bus.OpCode)
          6'h23, 6'h2b: w_next = S_MADR;
          6'h00:        w_next = w_jr ? S_JMP : (w_jalr ? S_LINK : S_EXE);
          6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0a, 6'h0b, 6'h0f: w_next = S_EXE;
          6'h04, 6'h05: w_next = S_BR;
          6'h02:        w_next = S_JMP;
          6'h03:        w_next = S_LINK;
`ifdef ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_IF;
`endif
        endcase
      end
      S_EXE: begin
        w_srca  = 2'b01;
        w_srcb  = w_rtype ? 2'b00 : 2'b10;
        w_extop = !((bus.OpCode == 6'h0c) || (bus.OpCode == 6'h0d));
        w_luiop = (bus.OpCode == 6'h0f);
        case (bus.OpCode)
          6'h00:        w_aluop[2:0] = 3'b010;
          6'h0c:        w_aluop[2:0] = 3'b100;
          6'h0d:        w_aluop[2:0] = 3'b011;
          6'h0a, 6'h0b: w_aluop[2:0] = 3'b101;
          default:      w_aluop[2:0] = 3'b000;
        endcase
        w_aluop[3] = bus.OpCode[0];
        w_next     = S_AWB;
      end
      S_AWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 2'b01;
        w_regdst   = w_rtype ? 2'b01 : 2'b00;
      end
      S_MADR: begin
        w_srca  = 2'b01;
        w_srcb  = 2'b10;
        w_extop = 1'b1;
        w_aluop = {bus.OpCode[0], 3'b000};
        w_next  = (bus.OpCode == 6'h2b) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        w_next    = w_mem_ok ? S_MWB : S_MRD;
      end
      S_MWB: w_regwrite = 1'b1;
      S_MWR: begin
        // MemWrite held for the whole access, including wait cycles
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_next     = w_mem_ok ? S_IF : S_MWR;
      end
      S_BR: begin
        w_srca    = 2'b01;
        w_aluop   = {bus.OpCode[0], 3'b001};
        w_pcwcond = 1'b1;
        w_pcsrc   = 2'b01;
        w_bne     = (bus.OpCode == 6'h05);
      end
      S_LINK: begin
        w_regwrite = 1'b1;
        w_memtoreg = 2'b10;
        w_regdst   = w_jalr ? 2'b01 : 2'b10;
        w_next     = S_JMP;
      end
      S_JMP: begin
        w_pcwrite = 1'b1;
        w_pcsrc   = w_rtype ? 2'b11 : 2'b10;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        // PCSource 00 here; the datapath swaps in the exception vector
        w_exc     = 1'b1;
        w_pcwrite = 1'b1;
      end
`endif
      default: w_next = S_IF;
    endcase
  end

  assign bus.PCWrite     = reset & w_pcwrite;
  assign bus.PCWriteCond = reset & w_pcwcond;
  assign bus.BranchNe    = reset & w_bne;
  assign bus.IorD        = reset & w_iord;
  assign bus.MemRead     = reset & w_memread;
  assign bus.MemWrite    = reset & w_memwrite;
  assign bus.IRWrite     = reset & w_irwrite;
  assign bus.RegWrite    = reset & w_regwrite;
  assign bus.ExtOp       = reset & w_extop;
  assign bus.LuiOp       = reset & w_luiop;
  assign bus.Exception   = reset & w_exc;
  assign bus.MemtoReg    = reset ? w_memtoreg : 2'b00;
  assign bus.RegDst      = reset ? w_regdst : 2'b00;
  assign bus.ALUSrcA     = reset ? w_srca : 2'b00;
  assign bus.ALUSrcB     = reset ? w_srcb : 2'b00;
  assign bus.PCSource    = reset ? w_pcsrc : 2'b00;
  assign bus.ALUOp       = reset ? ALUOP_W'(w_aluop) : '0;
  assign bus.State       = reset ? r_state : 4'd0;
endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// tb/tb_multicycle_ctrl_v2.sv - directed self-checking bench for multicycle_ctrl_v2
module tb_multicycle_ctrl_v2;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  multicycle_ctrl_v2_if #(.ALUOP_W(4)) bus();

  multicycle_ctrl_v2 #(.ALUOP_W(4), .MEM_HANDSHAKE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [28:0] w_all;
  assign w_all = {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.IorD, bus.MemRead,
                  bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ExtOp, bus.LuiOp,
                  bus.MemtoReg, bus.RegDst, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                  bus.PCSource, bus.Exception, bus.State};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic [3:0] st, input logic rw);
    bus.MemReady = rdy;
    #1;
    chk({tag, "_state"}, 32'(bus.State), 32'(st));
    chk({tag, "_regwrite"}, 32'(bus.RegWrite), 32'(rw));
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b0;
    bus.MemReady = 1'b1;
    bus.OpCode   = 6'h00;
    bus.Funct    = 6'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(w_all), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_state", 32'(bus.State), 32'd0);
    chk("rel_memread", 32'(bus.MemRead), 32'd1);
    chk("rel_irwrite", 32'(bus.IRWrite), 32'd1);
    chk("rel_pcwrite", 32'(bus.PCWrite), 32'd1);

    // IF wait state
    bus.OpCode   = 6'h23;
    bus.MemReady = 1'b0;
    #1;
    chk("ifwait_irwrite", 32'(bus.IRWrite), 32'd0);
    chk("ifwait_pcwrite", 32'(bus.PCWrite), 32'd0);
    tick;
    chk("ifwait_state", 32'(bus.State), 32'd0);

    // lw with two MemReady-low cycles in MRD
    cyc("lw0", 1'b1, 4'd0, 1'b0); tick;
    cyc("lw1", 1'b1, 4'd1, 1'b0); tick;
    cyc("lw2", 1'b1, 4'd2, 1'b0);
    chk("lw_madr_srcb", 32'(bus.ALUSrcB), 32'd2);
    tick;
    cyc("lw3a", 1'b0, 4'd3, 1'b0);
    chk("lw_mrd_iord", 32'(bus.IorD), 32'd1);
    chk("lw_mrd_memread", 32'(bus.MemRead), 32'd1);
    tick;
    cyc("lw3b", 1'b0, 4'd3, 1'b0); tick;
    cyc("lw3c", 1'b1, 4'd3, 1'b0); tick;
    cyc("lw4", 1'b1, 4'd4, 1'b1);
    chk("lw_mwb_memtoreg", 32'(bus.MemtoReg), 32'd0);
    tick;
    cyc("lw_end", 1'b1, 4'd0, 1'b0);

    // bne
    bus.OpCode = 6'h05;
    cyc("bne0", 1'b1, 4'd0, 1'b0); tick;
    cyc("bne1", 1'b1, 4'd1, 1'b0); tick;
    cyc("bne8", 1'b1, 4'd8, 1'b0);
    chk("bne_pcwcond", 32'(bus.PCWriteCond), 32'd1);
    chk("bne_branchne", 32'(bus.BranchNe), 32'd1);
    chk("bne_pcsource", 32'(bus.PCSource), 32'd1);
    chk("bne_aluop", 32'(bus.ALUOp), 32'h9);
    tick;
    cyc("bne_end", 1'b1, 4'd0, 1'b0);

    // jalr
    bus.OpCode = 6'h00;
    bus.Funct  = 6'h09;
    cyc("jalr0", 1'b1, 4'd0, 1'b0); tick;
    cyc("jalr1", 1'b1, 4'd1, 1'b0); tick;
    cyc("jalr10", 1'b1, 4'd10, 1'b1);
    chk("jalr_regdst", 32'(bus.RegDst), 32'd1);
    chk("jalr_memtoreg", 32'(bus.MemtoReg), 32'd2);
    tick;
    cyc("jalr9", 1'b1, 4'd9, 1'b0);
    chk("jalr_pcsource", 32'(bus.PCSource), 32'd3);
    chk("jalr_pcwrite", 32'(bus.PCWrite), 32'd1);
    tick;
    cyc("jalr_end", 1'b1, 4'd0, 1'b0);

    // R-type add
    bus.Funct = 6'h20;
    cyc("add0", 1'b1, 4'd0, 1'b0); tick;
    cyc("add1", 1'b1, 4'd1, 1'b0); tick;
    cyc("add6", 1'b1, 4'd6, 1'b0);
    chk("add_srca", 32'(bus.ALUSrcA), 32'd1);
    chk("add_srcb", 32'(bus.ALUSrcB), 32'd0);
    chk("add_aluop", 32'(bus.ALUOp), 32'h2);
    tick;
    cyc("add7", 1'b1, 4'd7, 1'b1);
    chk("add_regdst", 32'(bus.RegDst), 32'd1);
    chk("add_memtoreg", 32'(bus.MemtoReg), 32'd1);
    tick;
    cyc("add_end", 1'b1, 4'd0, 1'b0);

    // ori
    bus.OpCode = 6'h0d;
    cyc("ori0", 1'b1, 4'd0, 1'b0); tick;
    cyc("ori1", 1'b1, 4'd1, 1'b0); tick;
    cyc("ori6", 1'b1, 4'd6, 1'b0);
    chk("ori_aluop", 32'(bus.ALUOp), 32'hb);
    chk("ori_extop", 32'(bus.ExtOp), 32'd0);
    chk("ori_srcb", 32'(bus.ALUSrcB), 32'd2);
    tick;
    cyc("ori7", 1'b1, 4'd7, 1'b1);
    chk("ori_regdst", 32'(bus.RegDst), 32'd0);
    tick;
    cyc("ori_end", 1'b1, 4'd0, 1'b0);

    // illegal opcode
    bus.OpCode = 6'h3f;
    cyc("ill0", 1'b1, 4'd0, 1'b0);
    chk("ill0_exc", 32'(bus.Exception), 32'd0);
    tick;
    cyc("ill1", 1'b1, 4'd1, 1'b0);
    chk("ill1_exc", 32'(bus.Exception), 32'd0);
    tick;
`ifdef ILLEGAL_TRAP_EN
    cyc("ill11", 1'b1, 4'd11, 1'b0);
    chk("ill_trap_exc", 32'(bus.Exception), 32'd1);
    chk("ill_trap_pcwrite", 32'(bus.PCWrite), 32'd1);
    tick;
`endif
    cyc("ill_end", 1'b1, 4'd0, 1'b0);
    chk("ill_end_exc", 32'(bus.Exception), 32'd0);

    // sw interrupted by reset during a MWR wait
    bus.OpCode = 6'h2b;
    cyc("sw0", 1'b1, 4'd0, 1'b0); tick;
    cyc("sw1", 1'b1, 4'd1, 1'b0); tick;
    cyc("sw2", 1'b1, 4'd2, 1'b0); tick;
    cyc("sw5a", 1'b0, 4'd5, 1'b0);
    chk("sw_memwrite_a", 32'(bus.MemWrite), 32'd1);
    tick;
    cyc("sw5b", 1'b0, 4'd5, 1'b0);
    chk("sw_memwrite_b", 32'(bus.MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    chk("sw_rst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("sw_rst_outputs", 32'(w_all), 32'd0);
    tick;
    reset = 1'b1;
    #1;
    chk("sw_after_state", 32'(bus.State), 32'd0);
    chk("sw_after_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("sw_after_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("sw_after_memread", 32'(bus.MemRead), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
